// File: rtl/mac_accumulator.sv
// Frame accumulator: sums LEN products taken over a valid/ready handshake,
// then presents the total until it is accepted. Optional macro MAC_ACC_SAT_EN adds saturation and an overflow flag.
module mac_accumulator #(
   parameter int bw    = 4,
   parameter int LEN   = 4,
   parameter int ACC_W = 10,
   parameter int CNT_W = 2
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              clear,
   input  logic              p_valid,
   output logic              p_ready,
   input  logic [2*bw-1:0]   product,
   output logic [ACC_W-1:0]  sum,
   output logic              sum_valid,
   input  logic              sum_ready,
   output logic [CNT_W-1:0]  cnt,
   output logic              ovf
);

   typedef enum logic {ACC, HOLD} state_t;

`ifdef MAC_ACC_SAT_EN
   localparam int ADD_W = ACC_W + 1;
`else
   localparam int ADD_W = ACC_W;
`endif

   state_t             r_state, w_state_nxt;
   logic [ACC_W-1:0]   r_sum, w_sum_nxt, w_acc_sum;
   logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
   logic               r_sum_valid, w_sv_nxt;
   logic               r_ovf, w_ovf_nxt, w_acc_ovf;
   logic [ADD_W-1:0]   w_add;
   logic               w_accept;

   assign p_ready   = (r_state == ACC);
   assign w_accept  = p_valid & p_ready;
   assign w_add     = ADD_W'(r_sum) + ADD_W'(product);

   // Sum after adding the current product, with or without saturation.
   always_comb begin
`ifdef MAC_ACC_SAT_EN
      if (w_add[ADD_W-1] || r_ovf) begin
         w_acc_sum = '1;
         w_acc_ovf = 1'b1;
      end else begin
         w_acc_sum = w_add[ACC_W-1:0];
         w_acc_ovf = 1'b0;
      end
`else
      w_acc_sum = w_add;
      w_acc_ovf = 1'b0;
`endif
   end

   always_comb begin
      w_state_nxt = r_state;
      w_sum_nxt   = r_sum;
      w_cnt_nxt   = r_cnt;
      w_sv_nxt    = r_sum_valid;
      w_ovf_nxt   = r_ovf;
      if (clear) begin
         w_state_nxt = ACC;
         w_sum_nxt   = '0;
         w_cnt_nxt   = '0;
         w_sv_nxt    = 1'b0;
         w_ovf_nxt   = 1'b0;
      end else begin
         case (r_state)
            ACC: begin
               if (w_accept) begin
                  w_sum_nxt = w_acc_sum;
                  w_ovf_nxt = w_acc_ovf;
                  if (r_cnt == CNT_W'(LEN - 1)) begin
                     w_cnt_nxt   = '0;
                     w_sv_nxt    = 1'b1;
                     w_state_nxt = HOLD;
                  end else begin
                     w_cnt_nxt = r_cnt + 1'b1;
                  end
               end
            end
            HOLD: begin
               if (sum_ready) begin
                  w_sum_nxt   = '0;
                  w_ovf_nxt   = 1'b0;
                  w_sv_nxt    = 1'b0;
                  w_state_nxt = ACC;
               end
            end
            default: w_state_nxt = ACC;
         endcase
      end
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         r_state     <= ACC;
         r_sum       <= '0;
         r_cnt       <= '0;
         r_sum_valid <= 1'b0;
         r_ovf       <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_sum       <= w_sum_nxt;
         r_cnt       <= w_cnt_nxt;
         r_sum_valid <= w_sv_nxt;
         r_ovf       <= w_ovf_nxt;
      end
   end

   assign sum       = r_sum;
   assign cnt       = r_cnt;
   assign sum_valid = r_sum_valid;
   assign ovf       = r_ovf;

endmodule
